pwm_multi_axi: RTL and testbench
================================

// Module: pwm_multi_axi
// PURPOSE
//  Multi-channel PWM generator behind an AXI4-Lite slave; successor to the single-channel PMW IP.
//  One shared period counter drives NUM_CH compare channels.
//  PERIOD and DUTY are double-buffered: software writes shadow registers, hardware loads them at the period boundary.
//  A period-end interrupt lets the MicroBlaze update duty cycles glitch-free.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32  AXI data width; fixed at 32.
//  C_S_AXI_ADDR_WIDTH  6   byte address width; 16 word slots.
//  NUM_CH              4   PWM channels, 1..8.
//  CNT_W               16  counter/period/duty width, 1..32.
// PORTS
//  s00_axi_aclk     in   1       clock
//  s00_axi_aresetn  in   1       async active-low reset
//  s00_axi_aw*/w*/b*/ar*/r*      standard AXI4-Lite slave channels (awaddr/araddr ADDR_W, wdata/rdata 32, wstrb 4, resp 2)
//  pwm_out          out  NUM_CH  PWM outputs, registered
//  irq              out  1       level interrupt
// BEHAVIOUR
//  Reset (async assert, sync release)
//   - all outputs 0; all registers 0; counter 0; ready/valid signals low.
//  Register map (word offsets)
//   0x00 CTRL    [0] EN, [1] IRQ_EN, rw.
//   0x04 PERIOD  shadow, CNT_W bits, rw.
//   0x08 STATUS  [0] PEND, sticky; write-1-to-clear.
//   0x0C CH_EN   NUM_CH bits, rw.
//   0x10+4k DUTY[k] shadow, k<NUM_CH, rw.
//   Reads return shadow values.
//   Bits above a field's width read 0; writes to them are ignored.
//   WSTRB honoured per byte.
//  AXI4-Lite handshake
//   - one transaction per direction outstanding.
//   - AWREADY and WREADY pulse for one cycle only once both AWVALID and WVALID are high.
//   - BVALID is asserted the following cycle and held until BREADY.
//   - ARREADY pulses one cycle; RVALID follows a cycle later and is held until RREADY.
//   - decode miss (DUTY slot k>=NUM_CH, or 0x30 and above): write dropped, read data 0, BRESP/RRESP = SLVERR (2'b10); otherwise OKAY.
//   - a write and a read in the same cycle are both serviced, on independent channels.
//  Counter
//   - EN=0: cnt held at 0; active regs track shadow every cycle.
//   - EN=1: if cnt==per_act, then cnt<=0 and the load event fires; else cnt<=cnt+1.
//   - per_act==0: cnt stays 0; the load event fires every cycle.
//  Load event
//   - per_act<=PERIOD and duty_act[k]<=DUTY[k].
//   - PEND<=1 (only when EN=1).
//   - a PEND set and a W1C in the same cycle: the set wins.
//  Output
//   - pwm_out[k] <= EN & CH_EN[k] & (cnt < duty_act[k]); 1 cycle after cnt.
//   - duty_act>per_act: constant high.
//   - duty_act==0: constant low.
//   - comparison is unsigned, CNT_W bits.
//  irq = PEND & IRQ_EN, registered.
//  Writing EN 1->0 forces outputs low on the next edge and resets cnt; there is no mid-period completion.
//  Reset mid-transaction: all AXI valids drop immediately; the master must reissue.
// TESTING
//  T1 reset: aresetn=0 for 20 cycles -> pwm_out=0, irq=0, all registers read 0.
//  T2 basic: PERIOD=9, DUTY0=3, CH_EN=1, CTRL=1 -> pwm_out[0] is 3 high / 7 low, repeating every 10 cycles.
//  T3 shadow: mid-period, write DUTY0=6 -> current period unchanged; next period high for 6 cycles.
//  T4 bounds: DUTY1=0 gives constant low; DUTY2=12 with PERIOD=9 gives constant high; PERIOD=0 with DUTY=1 gives constant high.
//  T5 irq: IRQ_EN=1 -> irq rises after first wrap; write STATUS=1 -> irq low; it reasserts at the next wrap.
//  T6 AXI: write 0x10 with WSTRB=4'b0001 and data 0xFFFF -> reads 0x00FF; read 0x3C -> RRESP=2'b10, data 0.

Source files
------------

// File: rtl/pwm_multi_axi.sv
// Multi-channel PWM generator behind an AXI4-Lite slave. One shared period counter
// feeds NUM_CH compare channels; PERIOD/DUTY shadows are reloaded at each period boundary.
module pwm_multi_axi #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_CH             = 4,
    parameter int CNT_W              = 16
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic [NUM_CH-1:0]                 pwm_out,
    output logic                              irq
);

    localparam int SLOT_W = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [SLOT_W-1:0] SLOT_CTRL   = SLOT_W'(32'd0);
    localparam logic [SLOT_W-1:0] SLOT_PERIOD = SLOT_W'(32'd1);
    localparam logic [SLOT_W-1:0] SLOT_STATUS = SLOT_W'(32'd2);
    localparam logic [SLOT_W-1:0] SLOT_CHEN   = SLOT_W'(32'd3);
    localparam logic [SLOT_W-1:0] SLOT_END    = SLOT_W'(32'd4 + 32'(NUM_CH));
    localparam logic [1:0]        RESP_OKAY   = 2'b00;
    localparam logic [1:0]        RESP_SLVERR = 2'b10;

    // Byte-lane merge of a write into the current register contents.
    function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] mask;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    // Shadow registers, active copies and AXI channel state
    logic [1:0]                   ctrl_q, ctrl_d;
    logic [CNT_W-1:0]             period_q, period_d;
    logic                         pend_q, pend_d;
    logic [NUM_CH-1:0]            ch_en_q, ch_en_d;
    logic [NUM_CH-1:0][CNT_W-1:0] duty_q, duty_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [CNT_W-1:0]             per_act_q, per_act_d;
    logic [NUM_CH-1:0][CNT_W-1:0] duty_act_q, duty_act_d;
    logic [NUM_CH-1:0]            pwm_q, pwm_d;
    logic                         irq_q, irq_d;
    logic                         wr_ready_q, wr_ready_d;
    logic                         b_valid_q, b_valid_d;
    logic [1:0]                   b_resp_q, b_resp_d;
    logic                         ar_ready_q, ar_ready_d;
    logic                         r_valid_q, r_valid_d;
    logic [31:0]                  r_data_q, r_data_d;
    logic [1:0]                   r_resp_q, r_resp_d;

    logic [SLOT_W-1:0] wr_slot_s, rd_slot_s;
    logic              wr_start_s, wr_do_s, wr_hit_s;
    logic              rd_start_s, rd_do_s, rd_hit_s;
    logic [31:0]       rd_data_s;
    logic              load_s;
    logic              unused_addr_s;

    assign wr_slot_s     = s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign rd_slot_s     = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign wr_hit_s      = (wr_slot_s < SLOT_END);
    assign rd_hit_s      = (rd_slot_s < SLOT_END);
    assign unused_addr_s = ^{s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    // Address and data are accepted together; the ready pulse is the handshake cycle.
    assign wr_start_s = s00_axi_awvalid & s00_axi_wvalid & ~wr_ready_q & ~b_valid_q;
    assign wr_do_s    = wr_ready_q & s00_axi_awvalid & s00_axi_wvalid;
    assign rd_start_s = s00_axi_arvalid & ~ar_ready_q & ~r_valid_q;
    assign rd_do_s    = ar_ready_q & s00_axi_arvalid;
    assign load_s     = ctrl_q[0] & (cnt_q == per_act_q);

    // AXI channel handshake next state
    always_comb begin
        wr_ready_d = wr_start_s;
        ar_ready_d = rd_start_s;
        b_valid_d  = b_valid_q;
        b_resp_d   = b_resp_q;
        r_valid_d  = r_valid_q;
        r_data_d   = r_data_q;
        r_resp_d   = r_resp_q;
        if (wr_do_s) begin
            b_valid_d = 1'b1;
            b_resp_d  = wr_hit_s ? RESP_OKAY : RESP_SLVERR;
        end else if (s00_axi_bready) begin
            b_valid_d = 1'b0;
        end else begin
            b_valid_d = b_valid_q;
        end
        if (rd_do_s) begin
            r_valid_d = 1'b1;
            r_data_d  = rd_data_s;
            r_resp_d  = rd_hit_s ? RESP_OKAY : RESP_SLVERR;
        end else if (s00_axi_rready) begin
            r_valid_d = 1'b0;
        end else begin
            r_valid_d = r_valid_q;
        end
    end

    // Read data mux over the shadow registers; misses return zero
    always_comb begin
        rd_data_s = 32'd0;
        case (rd_slot_s)
            SLOT_CTRL:   rd_data_s = 32'(ctrl_q);
            SLOT_PERIOD: rd_data_s = 32'(period_q);
            SLOT_STATUS: rd_data_s = {31'd0, pend_q};
            SLOT_CHEN:   rd_data_s = 32'(ch_en_q);
            default: begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (rd_slot_s == SLOT_W'(32'd4 + 32'(k))) begin
                        rd_data_s = 32'(duty_q[k]);
                    end else begin
                        rd_data_s = rd_data_s;
                    end
                end
            end
        endcase
    end

    // Register file: software writes, then the load event sets PEND (set beats clear)
    always_comb begin
        ctrl_d   = ctrl_q;
        period_d = period_q;
        pend_d   = pend_q;
        ch_en_d  = ch_en_q;
        duty_d   = duty_q;
        if (wr_do_s && wr_hit_s) begin
            case (wr_slot_s)
                SLOT_CTRL:   ctrl_d   = 2'(strb_merge(32'(ctrl_q), s00_axi_wdata, s00_axi_wstrb));
                SLOT_PERIOD: period_d = CNT_W'(strb_merge(32'(period_q), s00_axi_wdata, s00_axi_wstrb));
                SLOT_STATUS: begin
                    if (s00_axi_wstrb[0] && s00_axi_wdata[0]) begin
                        pend_d = 1'b0;
                    end else begin
                        pend_d = pend_q;
                    end
                end
                SLOT_CHEN:   ch_en_d  = NUM_CH'(strb_merge(32'(ch_en_q), s00_axi_wdata, s00_axi_wstrb));
                default: begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (wr_slot_s == SLOT_W'(32'd4 + 32'(k))) begin
                            duty_d[k] = CNT_W'(strb_merge(32'(duty_q[k]), s00_axi_wdata, s00_axi_wstrb));
                        end else begin
                            duty_d[k] = duty_q[k];
                        end
                    end
                end
            endcase
        end else begin
            ctrl_d = ctrl_q;
        end
        if (load_s) begin
            pend_d = 1'b1;
        end else begin
            pend_d = pend_d;
        end
    end

    // Period counter, active-register reload and channel compare
    always_comb begin
        cnt_d      = cnt_q;
        per_act_d  = per_act_q;
        duty_act_d = duty_act_q;
        pwm_d      = '0;
        if (!ctrl_q[0]) begin
            cnt_d      = '0;
            per_act_d  = period_q;
            duty_act_d = duty_q;
        end else if (load_s) begin
            cnt_d      = '0;
            per_act_d  = period_q;
            duty_act_d = duty_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(32'd1);
        end
        for (int k = 0; k < NUM_CH; k++) begin
            pwm_d[k] = ctrl_q[0] & ch_en_q[k] & (cnt_q < duty_act_q[k]);
        end
        irq_d = pend_q & ctrl_q[1];
    end

    // State registers
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            ctrl_q     <= '0;
            period_q   <= '0;
            pend_q     <= 1'b0;
            ch_en_q    <= '0;
            duty_q     <= '0;
            cnt_q      <= '0;
            per_act_q  <= '0;
            duty_act_q <= '0;
            pwm_q      <= '0;
            irq_q      <= 1'b0;
            wr_ready_q <= 1'b0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= 2'b00;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_data_q   <= 32'd0;
            r_resp_q   <= 2'b00;
        end else begin
            ctrl_q     <= ctrl_d;
            period_q   <= period_d;
            pend_q     <= pend_d;
            ch_en_q    <= ch_en_d;
            duty_q     <= duty_d;
            cnt_q      <= cnt_d;
            per_act_q  <= per_act_d;
            duty_act_q <= duty_act_d;
            pwm_q      <= pwm_d;
            irq_q      <= irq_d;
            wr_ready_q <= wr_ready_d;
            b_valid_q  <= b_valid_d;
            b_resp_q   <= b_resp_d;
            ar_ready_q <= ar_ready_d;
            r_valid_q  <= r_valid_d;
            r_data_q   <= r_data_d;
            r_resp_q   <= r_resp_d;
        end
    end

    assign s00_axi_awready = wr_ready_q;
    assign s00_axi_wready  = wr_ready_q;
    assign s00_axi_bvalid  = b_valid_q;
    assign s00_axi_bresp   = b_resp_q;
    assign s00_axi_arready = ar_ready_q;
    assign s00_axi_rvalid  = r_valid_q;
    assign s00_axi_rdata   = r_data_q;
    assign s00_axi_rresp   = r_resp_q;
    assign pwm_out         = pwm_q;
    assign irq             = irq_q;

endmodule

// File: tb/tb_pwm_multi_axi.sv
// Self-checking bench for pwm_multi_axi: register-map vector table plus hand-written
// PWM, shadow-reload, bounds, interrupt and reset sequences.
module tb_pwm_multi_axi;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [5:0]        awaddr, araddr;
    logic              awvalid, wvalid, bready, arvalid, rready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              awready, wready, bvalid, arready, rvalid;
    logic [1:0]        bresp, rresp;
    logic [31:0]       rdata;
    logic [NUM_CH-1:0] pwm_out;
    logic              irq;
    logic [NUM_CH:0]   obs;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } vec_t;
    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    logic [1:0] b_q[$];
    rexp_t      r_q[$];
    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic [NUM_CH:0] hist [0:4095];

    pwm_multi_axi #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6), .NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
        .s00_axi_awaddr(awaddr), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
        .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
        .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
        .s00_axi_araddr(araddr), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
        .pwm_out(pwm_out), .irq(irq)
    );

    always #5 clk = ~clk;
    assign obs = {irq, pwm_out};

    // History of {irq, pwm_out} sampled mid-cycle
    always @(negedge clk) begin
        if (cyc < 4096) hist[cyc] <= obs;
        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] er, input string name);
        int n;
        logic [1:0] e;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        b_q.push_back(er);
        n = 0;
        while (!awready && n < 50) begin @(negedge clk); n++; end
        check({name, " awready"}, 32'(awready & wready), 32'd1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        n = 0;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        check({name, " bvalid"}, 32'(bvalid), 32'd1);
        if (b_q.size() > 0) begin
            e = b_q.pop_front();
            check({name, " bresp"}, 32'(bresp), 32'(e));
        end else begin
            n_cmp++; n_fail++;
            $display("FAIL %s: write response with empty scoreboard", name);
        end
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [5:0] a, input logic [31:0] ed, input logic [1:0] er,
                            input string name);
        int n;
        rexp_t e;
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        r_q.push_back({ed, er});
        n = 0;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        check({name, " arready"}, 32'(arready), 32'd1);
        @(negedge clk);
        arvalid = 1'b0; rready = 1'b1;
        n = 0;
        while (!rvalid && n < 50) begin @(negedge clk); n++; end
        check({name, " rvalid"}, 32'(rvalid), 32'd1);
        if (r_q.size() > 0) begin
            e = r_q.pop_front();
            check({name, " rdata"}, rdata, e.data);
            check({name, " rresp"}, 32'(rresp), 32'(e.resp));
        end else begin
            n_cmp++; n_fail++;
            $display("FAIL %s: read data with empty scoreboard", name);
        end
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic wait_bit(input int b, input logic v, input string name);
        int n = 0;
        while (obs[b] !== v && n < 40) begin @(negedge clk); n++; end
        check(name, 32'(obs[b]), 32'(v));
    endtask

    function automatic int find_rise(input int b, input int from, input int upto);
        for (int i = from + 1; i < upto && i < 4096; i++) begin
            if (i > 0 && hist[i][b] && !hist[i-1][b]) return i;
        end
        return -1;
    endfunction

    function automatic int run_len(input int b, input int r, input int upto);
        int l = 0;
        if (r < 0) return 0;
        while (r + l < upto && r + l < 4096 && hist[r+l][b]) l++;
        return l;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [11];
        int t0, r1, r2, h1, h2;

        vecs[0]  = '{6'h04, 32'hFFFF_FFFF, 4'hF, 32'h0000_FFFF, 2'b00};
        vecs[1]  = '{6'h0C, 32'hFFFF_FFFF, 4'hF, 32'h0000_000F, 2'b00};
        vecs[2]  = '{6'h10, 32'h0000_FFFF, 4'h1, 32'h0000_00FF, 2'b00};
        vecs[3]  = '{6'h14, 32'h1234_5678, 4'h2, 32'h0000_5600, 2'b00};
        vecs[4]  = '{6'h1C, 32'hABCD_1234, 4'hC, 32'h0000_0000, 2'b00};
        vecs[5]  = '{6'h20, 32'h0000_0055, 4'hF, 32'h0000_0000, 2'b10};
        vecs[6]  = '{6'h3C, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 2'b10};
        vecs[7]  = '{6'h30, 32'h0000_0001, 4'hF, 32'h0000_0000, 2'b10};
        vecs[8]  = '{6'h00, 32'hFFFF_FFFC, 4'hF, 32'h0000_0000, 2'b00};
        vecs[9]  = '{6'h18, 32'h0000_BEEF, 4'h3, 32'h0000_BEEF, 2'b00};
        vecs[10] = '{6'h08, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 2'b00};

        rst_n = 1'b0;
        awaddr = 6'd0; araddr = 6'd0; wdata = 32'd0; wstrb = 4'd0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;

        // T1 reset
        repeat (20) @(negedge clk);
        check("reset pwm_out", 32'(pwm_out), 32'd0);
        check("reset irq", 32'(irq), 32'd0);
        check("reset awready", 32'(awready), 32'd0);
        check("reset bvalid", 32'(bvalid), 32'd0);
        check("reset arready", 32'(arready), 32'd0);
        check("reset rvalid", 32'(rvalid), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            axi_read(6'(i * 4), 32'd0, 2'b00, $sformatf("reset reg%0d", i));
        end

        // Register map table, including T6 byte-strobe and decode-miss cases
        for (int i = 0; i < 11; i++) begin
            axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].resp, $sformatf("vec%0d wr", i));
            axi_read(vecs[i].addr, vecs[i].rdata, vecs[i].resp, $sformatf("vec%0d rd", i));
        end

        // T2 basic waveform: 3 high / 7 low
        axi_write(6'h04, 32'd9, 4'hF, 2'b00, "T2 period");
        axi_write(6'h10, 32'd3, 4'hF, 2'b00, "T2 duty0");
        axi_write(6'h0C, 32'd1, 4'hF, 2'b00, "T2 chen");
        axi_write(6'h00, 32'd1, 4'hF, 2'b00, "T2 ctrl");
        t0 = cyc;
        repeat (35) @(negedge clk);
        r1 = find_rise(0, t0, cyc);
        r2 = find_rise(0, r1, cyc);
        check("T2 high len 1", 32'(run_len(0, r1, cyc)), 32'd3);
        check("T2 high len 2", 32'(run_len(0, r2, cyc)), 32'd3);
        check("T2 period", 32'(r2 - r1), 32'd10);
        check("T2 other ch low", 32'(pwm_out[3:1]), 32'd0);

        // T3 shadow DUTY update mid-period
        t0 = cyc;
        wait_bit(0, 1'b0, "T3 wait low");
        wait_bit(0, 1'b1, "T3 wait high");
        axi_write(6'h10, 32'd6, 4'hF, 2'b00, "T3 duty0");
        repeat (30) @(negedge clk);
        r1 = find_rise(0, t0, cyc);
        r2 = find_rise(0, r1, cyc);
        check("T3 current period", 32'(run_len(0, r1, cyc)), 32'd3);
        check("T3 next period", 32'(run_len(0, r2, cyc)), 32'd6);
        check("T3 spacing", 32'(r2 - r1), 32'd10);

        // T4 bounds: duty 0, duty > period, period 0
        axi_write(6'h14, 32'd0, 4'hF, 2'b00, "T4 duty1");
        axi_write(6'h18, 32'd12, 4'hF, 2'b00, "T4 duty2");
        axi_write(6'h0C, 32'd7, 4'hF, 2'b00, "T4 chen");
        repeat (25) @(negedge clk);
        h1 = 0; h2 = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            h1 += int'(pwm_out[1]);
            h2 += int'(pwm_out[2]);
        end
        check("T4 duty0 const low", 32'(h1), 32'd0);
        check("T4 duty>period const high", 32'(h2), 32'd20);
        axi_write(6'h04, 32'd0, 4'hF, 2'b00, "T4 period0");
        axi_write(6'h1C, 32'd1, 4'hF, 2'b00, "T4 duty3");
        axi_write(6'h0C, 32'hF, 4'hF, 2'b00, "T4 chen all");
        repeat (25) @(negedge clk);
        h1 = 0; h2 = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            h1 += int'(pwm_out[3]);
            h2 += int'(pwm_out[1]);
        end
        check("T4 period0 const high", 32'(h1), 32'd20);
        check("T4 period0 duty0 low", 32'(h2), 32'd0);

        // Simultaneous write and read on independent channels
        fork
            axi_write(6'h0C, 32'd5, 4'hF, 2'b00, "par wr");
            axi_read(6'h04, 32'd0, 2'b00, "par rd");
        join
        axi_read(6'h0C, 32'd5, 2'b00, "par chen");

        // T5 interrupt
        axi_write(6'h00, 32'd0, 4'hF, 2'b00, "T5 disable");
        axi_write(6'h08, 32'd1, 4'h1, 2'b00, "T5 clear");
        axi_read(6'h08, 32'd0, 2'b00, "T5 status clr");
        check("T5 irq idle", 32'(irq), 32'd0);
        axi_write(6'h04, 32'd9, 4'hF, 2'b00, "T5 period");
        t0 = cyc;
        axi_write(6'h00, 32'd3, 4'hF, 2'b00, "T5 enable");
        check("T5 irq before wrap", 32'(irq), 32'd0);
        wait_bit(NUM_CH, 1'b1, "T5 irq rise");
        axi_write(6'h08, 32'd1, 4'h1, 2'b00, "T5 w1c");
        check("T5 irq cleared", 32'(irq), 32'd0);
        wait_bit(NUM_CH, 1'b1, "T5 irq reassert");
        repeat (2) @(negedge clk);
        r1 = find_rise(NUM_CH, t0, cyc);
        r2 = find_rise(NUM_CH, r1, cyc);
        check("T5 irq spacing", 32'(r2 - r1), 32'd10);
        axi_read(6'h08, 32'd1, 2'b00, "T5 status pend");

        // EN 1->0 forces outputs low
        axi_write(6'h00, 32'd0, 4'hF, 2'b00, "EN off");
        check("EN off pwm", 32'(pwm_out), 32'd0);
        check("EN off irq", 32'(irq), 32'd0);

        // Reset in the middle of a read transaction
        @(negedge clk);
        araddr = 6'h04; arvalid = 1'b1;
        @(negedge clk);
        check("midrst arready before", 32'(arready), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst arready", 32'(arready), 32'd0);
        check("midrst rvalid", 32'(rvalid), 32'd0);
        arvalid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        axi_read(6'h04, 32'd0, 2'b00, "midrst period");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
